// File: rtl/ecc_point_seq.sv
// ecc_point_seq: sequences a single GFAU through affine EC point addition (optional doubling) over GF(p).
// Latency: accept -> CHECK -> per op (ISSUE + WAIT) -> FIN; a degenerate input finishes 3 cycles after i_start.
// Backpressure: i_start is taken only in IDLE; each GFAU op waits for i_gf_done or aborts after TIMEOUT_CYCLES.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_start, i_double          request (IDLE only), doubling select
//   i_x1,i_y1,i_x2,i_y2,i_a    operand points and curve coefficient a
//   i_prime                    field prime; the GFAU owns the modulus, so it is not consumed here
//   o_busy,o_done,o_err        status; o_err is 0 ok, 1 degenerate, 2 GFAU timeout (valid with o_done)
//   o_x3,o_y3                  result point, held until the next completion
//   o_gf_in_0,o_gf_in_1,o_gf_op,o_gf_start / i_gf_result,i_gf_done   GFAU handshake
//
// Build option: define ECC_POINT_DOUBLE_EN to enable the point-doubling prefix program.
module ecc_point_seq #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_double,
    input  logic [WIDTH-1:0] i_x1,
    input  logic [WIDTH-1:0] i_y1,
    input  logic [WIDTH-1:0] i_x2,
    input  logic [WIDTH-1:0] i_y2,
    input  logic [WIDTH-1:0] i_prime,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_err,
    output logic [WIDTH-1:0] o_x3,
    output logic [WIDTH-1:0] o_y3,
    output logic [WIDTH-1:0] o_gf_in_0,
    output logic [WIDTH-1:0] o_gf_in_1,
    output logic [1:0]       o_gf_op,
    output logic             o_gf_start,
    input  logic [WIDTH-1:0] i_gf_result,
    input  logic             i_gf_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    // operand sources
    localparam logic [3:0] SRC_X1 = 4'd0;
    localparam logic [3:0] SRC_Y1 = 4'd1;
    localparam logic [3:0] SRC_X2 = 4'd2;
    localparam logic [3:0] SRC_Y2 = 4'd3;
    localparam logic [3:0] SRC_A  = 4'd4;
    localparam logic [3:0] SRC_T0 = 4'd5;
    localparam logic [3:0] SRC_T1 = 4'd6;
    localparam logic [3:0] SRC_L  = 4'd7;
    localparam logic [3:0] SRC_X3 = 4'd8;

    // result destinations
    localparam logic [2:0] DST_T0 = 3'd0;
    localparam logic [2:0] DST_T1 = 3'd1;
    localparam logic [2:0] DST_L  = 3'd2;
    localparam logic [2:0] DST_X3 = 3'd3;
    localparam logic [2:0] DST_Y3 = 3'd4;

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]       r_state;
    logic [3:0]       r_step;
    logic [CW-1:0]    r_cnt;
    logic             r_dbl;
    logic [WIDTH-1:0] r_x1, r_y1, r_x2, r_y2, r_a;
    logic [WIDTH-1:0] r_t0, r_t1, r_l, r_tx3, r_ty3;
    logic             r_busy, r_done, r_gf_start;
    logic [1:0]       r_err, r_gf_op;
    logic [WIDTH-1:0] r_x3, r_y3, r_gf_in_0, r_gf_in_1;

    logic [1:0]       w_op;
    logic [3:0]       w_s0, w_s1;
    logic [2:0]       w_dst;
    logic             w_last;
    logic [3:0]       w_aidx;
    logic [WIDTH-1:0] w_in0, w_in1;

    // The GFAU holds the modulus; i_prime is part of the request bundle only.
    // i_double/i_a are also folded here so a build without doubling stays lint-quiet.
    logic w_unused;
    assign w_unused = ^{i_prime, i_double, i_a, i_y2};

    // Program decode. The doubling prefix occupies steps 0-5, after which the
    // add program resumes at its step 3, so add index = step - 3.
    always_comb begin
        w_op   = OP_ADD;
        w_s0   = SRC_X1;
        w_s1   = SRC_X1;
        w_dst  = DST_T0;
        w_aidx = r_step;
`ifdef ECC_POINT_DOUBLE_EN
        if (r_dbl) begin
            w_aidx = r_step - 4'd3;
        end
`endif
        w_last = (w_aidx == 4'd8);
        case (w_aidx)
            4'd0:    begin w_op = OP_SUB;  w_s0 = SRC_Y2; w_s1 = SRC_Y1; w_dst = DST_T0; end
            4'd1:    begin w_op = OP_SUB;  w_s0 = SRC_X2; w_s1 = SRC_X1; w_dst = DST_T1; end
            4'd2:    begin w_op = OP_DIV;  w_s0 = SRC_T0; w_s1 = SRC_T1; w_dst = DST_L;  end
            4'd3:    begin w_op = OP_MULT; w_s0 = SRC_L;  w_s1 = SRC_L;  w_dst = DST_T0; end
            4'd4:    begin w_op = OP_SUB;  w_s0 = SRC_T0; w_s1 = SRC_X1; w_dst = DST_T0; end
            4'd5:    begin w_op = OP_SUB;  w_s0 = SRC_T0; w_s1 = SRC_X2; w_dst = DST_X3; end
            4'd6:    begin w_op = OP_SUB;  w_s0 = SRC_X1; w_s1 = SRC_X3; w_dst = DST_T1; end
            4'd7:    begin w_op = OP_MULT; w_s0 = SRC_L;  w_s1 = SRC_T1; w_dst = DST_T0; end
            4'd8:    begin w_op = OP_SUB;  w_s0 = SRC_T0; w_s1 = SRC_Y1; w_dst = DST_Y3; end
            default: begin w_op = OP_ADD;  w_s0 = SRC_X1; w_s1 = SRC_X1; w_dst = DST_T0; end
        endcase
`ifdef ECC_POINT_DOUBLE_EN
        if (r_dbl && (r_step < 4'd6)) begin
            w_last = 1'b0;
            case (r_step)
                4'd0:    begin w_op = OP_MULT; w_s0 = SRC_X1; w_s1 = SRC_X1; w_dst = DST_T0; end
                4'd1:    begin w_op = OP_ADD;  w_s0 = SRC_T0; w_s1 = SRC_T0; w_dst = DST_T1; end
                4'd2:    begin w_op = OP_ADD;  w_s0 = SRC_T1; w_s1 = SRC_T0; w_dst = DST_T1; end
                4'd3:    begin w_op = OP_ADD;  w_s0 = SRC_T1; w_s1 = SRC_A;  w_dst = DST_T1; end
                4'd4:    begin w_op = OP_ADD;  w_s0 = SRC_Y1; w_s1 = SRC_Y1; w_dst = DST_T0; end
                default: begin w_op = OP_DIV;  w_s0 = SRC_T1; w_s1 = SRC_T0; w_dst = DST_L;  end
            endcase
        end
`endif
    end

    function automatic logic [WIDTH-1:0] f_src(
        input logic [3:0]       sel,
        input logic [WIDTH-1:0] x1, y1, x2, y2, a, t0, t1, l, x3
    );
        case (sel)
            SRC_X1:  f_src = x1;
            SRC_Y1:  f_src = y1;
            SRC_X2:  f_src = x2;
            SRC_Y2:  f_src = y2;
            SRC_A:   f_src = a;
            SRC_T0:  f_src = t0;
            SRC_T1:  f_src = t1;
            SRC_L:   f_src = l;
            SRC_X3:  f_src = x3;
            default: f_src = '0;
        endcase
    endfunction

    assign w_in0 = f_src(w_s0, r_x1, r_y1, r_x2, r_y2, r_a, r_t0, r_t1, r_l, r_tx3);
    assign w_in1 = f_src(w_s1, r_x1, r_y1, r_x2, r_y2, r_a, r_t0, r_t1, r_l, r_tx3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_cnt      <= '0;
            r_dbl      <= 1'b0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_x2       <= '0;
            r_y2       <= '0;
            r_a        <= '0;
            r_t0       <= '0;
            r_t1       <= '0;
            r_l        <= '0;
            r_tx3      <= '0;
            r_ty3      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 2'd0;
            r_x3       <= '0;
            r_y3       <= '0;
            r_gf_start <= 1'b0;
            r_gf_op    <= 2'd0;
            r_gf_in_0  <= '0;
            r_gf_in_1  <= '0;
        end else begin
            r_gf_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x1   <= i_x1;
                        r_y1   <= i_y1;
                        r_y2   <= i_y2;
                        r_a    <= i_a;
`ifdef ECC_POINT_DOUBLE_EN
                        // doubling reuses the add tail with x2 taken as x1
                        r_dbl  <= i_double;
                        r_x2   <= i_double ? i_x1 : i_x2;
`else
                        r_dbl  <= 1'b0;
                        r_x2   <= i_x2;
`endif
                        r_err   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((!r_dbl && (r_x1 == r_x2)) || (r_dbl && (r_y1 == '0))) begin
                        r_err   <= 2'd1;
                        r_state <= S_FIN;
                    end else begin
                        r_step  <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_gf_op    <= w_op;
                    r_gf_in_0  <= w_in0;
                    r_gf_in_1  <= w_in1;
                    r_gf_start <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_gf_done) begin
                        case (w_dst)
                            DST_T0:  r_t0  <= i_gf_result;
                            DST_T1:  r_t1  <= i_gf_result;
                            DST_L:   r_l   <= i_gf_result;
                            DST_X3:  r_tx3 <= i_gf_result;
                            default: r_ty3 <= i_gf_result;
                        endcase
                        r_cnt <= '0;
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_step  <= r_step + 4'd1;
                            r_state <= S_ISSUE;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 2'd2;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_x3    <= (r_err == 2'd0) ? r_tx3 : '0;
                    r_y3    <= (r_err == 2'd0) ? r_ty3 : '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_x3       = r_x3;
    assign o_y3       = r_y3;
    assign o_gf_in_0  = r_gf_in_0;
    assign o_gf_in_1  = r_gf_in_1;
    assign o_gf_op    = r_gf_op;
    assign o_gf_start = r_gf_start;

endmodule
